// File: rtl/lab_11_decim_fifo.sv
// lab_11_decim_fifo: decimator and first-word-fall-through FIFO behind the moving-average LPF.
// Keeps every DECIM-th valid input sample and queues it for a valid/ready consumer.
// The LPF cannot be stalled, so a kept sample that finds the FIFO full is discarded
// and counted in a saturating drop counter.
module lab_11_decim_fifo #(
    parameter int WIDTH = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     clr_i,
    input  logic [WIDTH-1:0]         snk_data_i,
    input  logic                     snk_valid_i,
    output logic [WIDTH-1:0]         src_data_o,
    output logic                     src_valid_o,
    input  logic                     src_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // A 1-bit phase register is kept even for DECIM=1 so the widths stay legal.
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PH_W-1:0]  phase_q,  phase_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [CNT_W-1:0] drop_q,   drop_d;
    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] data_q,   data_d;

    logic pop;
    logic push_req;
    logic full;
    logic push;
    logic drop;
    logic empty_after_pop;

    // Handshake decode: which of push, pop and drop happen this cycle.
    always_comb begin
        pop             = valid_q & src_ready_i;
        push_req        = snk_valid_i && (phase_q == PH_LAST);
        full            = (level_q == LVL_FULL);
        // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
        push            = push_req && (!full || pop);
        drop            = push_req && full && !pop;
        empty_after_pop = (level_q == '0) || ((level_q == LVL_ONE) && pop);
    end

    // Next-state for phase, pointers, occupancy, drop counter and the registered head.
    always_comb begin
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        valid_d  = valid_q;
        data_d   = data_q;

        // The phase only moves on real samples; gaps in snk_valid_i do not count.
        if (snk_valid_i) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Occupancy is tracked explicitly so full and empty are never ambiguous.
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (drop && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_W'(1);
        end

        valid_d = (level_d != '0);

        // Head register: a sample entering an otherwise-empty FIFO bypasses the array;
        // otherwise the head is whatever entry the read pointer lands on. When the
        // FIFO drains, the last value is simply held.
        if (push && empty_after_pop) begin
            data_d = snk_data_i;
        end else if (level_d != '0) begin
            data_d = mem_q[rd_ptr_d];
        end

        // Clear wins over everything; the sample arriving in this cycle is lost silently.
        if (clr_i) begin
            phase_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = '0;
            valid_d  = 1'b0;
            data_d   = data_q;
        end
    end

    // Control and head state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Sample storage; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            mem_q[wr_ptr_q] <= snk_data_i;
        end
    end

    assign src_data_o  = data_q;
    assign src_valid_o = valid_q;
    assign level_o     = level_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_lab_11_decim_fifo.sv
// tb_lab_11_decim_fifo: directed bench for the decimating FWFT FIFO (DECIM=4, DEPTH=8, CNT_W=4).
module tb_lab_11_decim_fifo;

    logic        clk;
    logic        arst_n;
    logic        clr;
    logic [15:0] snk_data;
    logic        snk_valid;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [3:0]  level;
    logic [3:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    lab_11_decim_fifo #(
        .WIDTH(16),
        .DECIM(4),
        .DEPTH(8),
        .CNT_W(4)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .clr_i       (clr),
        .snk_data_i  (snk_data),
        .snk_valid_i (snk_valid),
        .src_data_o  (src_data),
        .src_valid_o (src_valid),
        .src_ready_i (src_ready),
        .level_o     (level),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
        snk_valid = v;
        snk_data  = d;
        src_ready = r;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n    = 1'b0;
        clr       = 1'b0;
        snk_data  = '0;
        snk_valid = 1'b0;
        src_ready = 1'b0;

        // Reset state, before any clock edge
        #1;
        chk("rst_valid", 32'(src_valid), 0);
        chk("rst_data",  32'(src_data),  0);
        chk("rst_level", 32'(level),     0);
        chk("rst_drop",  32'(drop_cnt),  0);
        #6 arst_n = 1'b1;

        // 1: continuous input, consumer always ready
        for (int d = 1; d <= 16; d++) begin
            step(1'b1, 16'(d), 1'b1, 1'b0);
            chk("t1_valid", 32'(src_valid), (d % 4 == 0) ? 1 : 0);
            if (d % 4 == 0) chk("t1_data", 32'(src_data), 32'(d));
        end
        step(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t1_drained", 32'(src_valid), 0);
        chk("t1_drop",    32'(drop_cnt),  0);

        // 2: valid on alternate cycles
        step(1'b0, 16'd0, 1'b1, 1'b1);
        for (int d = 1; d <= 8; d++) begin
            step(1'b1, 16'(d), 1'b1, 1'b0);
            chk("t2_valid", 32'(src_valid), (d % 4 == 0) ? 1 : 0);
            if (d % 4 == 0) chk("t2_data", 32'(src_data), 32'(d));
            step(1'b0, 16'd99, 1'b1, 1'b0);
            chk("t2_gap_valid", 32'(src_valid), 0);
        end

        // 3: overflow with consumer stalled, then drain
        step(1'b0, 16'd0, 1'b0, 1'b1);
        for (int d = 1; d <= 44; d++) step(1'b1, 16'(d), 1'b0, 1'b0);
        chk("t3_level", 32'(level),    8);
        chk("t3_drop",  32'(drop_cnt), 3);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_out_valid", 32'(src_valid), 1);
            chk("t3_out_data",  32'(src_data),  32'(4 * i));
            step(1'b0, 16'd0, 1'b1, 1'b0);
        end
        chk("t3_empty_valid", 32'(src_valid), 0);
        chk("t3_empty_level", 32'(level),     0);

        // 4: push and pop together while full
        step(1'b0, 16'd0, 1'b0, 1'b1);
        for (int d = 1; d <= 32; d++) step(1'b1, 16'(d), 1'b0, 1'b0);
        chk("t4_full", 32'(level), 8);
        step(1'b1, 16'd100, 1'b0, 1'b0);
        step(1'b1, 16'd101, 1'b0, 1'b0);
        step(1'b1, 16'd102, 1'b0, 1'b0);
        chk("t4_no_push_level", 32'(level), 8);
        step(1'b1, 16'd103, 1'b1, 1'b0);
        chk("t4_level", 32'(level),    8);
        chk("t4_drop",  32'(drop_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_order", 32'(src_data), (i < 7) ? 32'(8 + 4 * i) : 32'd103);
            step(1'b0, 16'd0, 1'b1, 1'b0);
        end
        chk("t4_empty", 32'(src_valid), 0);

        // 5: drop counter saturates at 15 with the FIFO held full
        step(1'b0, 16'd0, 1'b0, 1'b1);
        for (int d = 1; d <= 92; d++) step(1'b1, 16'(d), 1'b0, 1'b0);
        chk("t5_drop_15", 32'(drop_cnt), 15);
        for (int d = 93; d <= 112; d++) step(1'b1, 16'(d), 1'b0, 1'b0);
        chk("t5_drop_hold", 32'(drop_cnt), 15);
        chk("t5_level",     32'(level),    8);
        chk("t5_head",      32'(src_data), 4);

        // 6a: asynchronous reset mid-stream, between clock edges
        arst_n = 1'b0;
        #2;
        chk("t6a_valid", 32'(src_valid), 0);
        chk("t6a_data",  32'(src_data),  0);
        chk("t6a_level", 32'(level),     0);
        chk("t6a_drop",  32'(drop_cnt),  0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            step(1'b1, 16'(d), 1'b1, 1'b0);
            chk("t6a_after_valid", 32'(src_valid), (d == 4) ? 1 : 0);
        end
        chk("t6a_after_data", 32'(src_data), 4);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // 6b: clear coinciding with a push
        step(1'b1, 16'd5, 1'b0, 1'b0);
        step(1'b1, 16'd6, 1'b0, 1'b0);
        step(1'b1, 16'd7, 1'b0, 1'b0);
        step(1'b1, 16'd8, 1'b0, 1'b1);
        chk("t6b_level", 32'(level),     0);
        chk("t6b_valid", 32'(src_valid), 0);
        chk("t6b_drop",  32'(drop_cnt),  0);
        step(1'b1, 16'd9,  1'b0, 1'b0);
        step(1'b1, 16'd10, 1'b0, 1'b0);
        step(1'b1, 16'd11, 1'b0, 1'b0);
        chk("t6b_phase_restart", 32'(src_valid), 0);
        step(1'b1, 16'd12, 1'b0, 1'b0);
        chk("t6b_first_valid", 32'(src_valid), 1);
        chk("t6b_first_data",  32'(src_data),  12);
        chk("t6b_first_level", 32'(level),     1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
